// File: rtl/mcu_subsys_bus_arbiter.sv
// mcu_subsys_bus_arbiter
// Two-master, one-slave round-robin arbiter for the MCU subsystem native
// memory bus. Master 0 is the CPU, master 1 is the DMA / debug loader; the
// slave is the host bridge address decoder. The owner is registered and
// holds the bus for exactly one transaction.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a 16-bit stall counter force-completes a transaction after
//               TIMEOUT_CYCLES busy cycles without s_ready, returning
//               ERR_RDATA and pulsing timeout_err.
//   undefined : BUSY waits for s_ready indefinitely, timeout_err reads 0.
//
// Ports:
//   sys_clk, rst        rising-edge clock, synchronous active-high reset
//   m0_* / m1_*         master request (valid/addr/wdata/wstrb) and
//                       completion (ready strobe, rdata valid with ready)
//   s_*                 muxed request to the slave and its response
//   grant               one-hot registered owner, 00 when idle
//   timeout_err         one-cycle pulse on a forced completion
module mcu_subsys_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_r;
  logic        owner_nxt_s;
  logic        last_owner_r;
  logic        last_owner_nxt_s;
  logic        busy_s;
  logic        own_valid_s;
  logic [31:0] own_addr_s;
  logic [31:0] own_wdata_s;
  logic [3:0]  own_wstrb_s;
  logic        done_s;
  logic        timeout_hit_s;
  logic        complete_s;
  logic [31:0] cpl_rdata_s;

  assign busy_s = (state_r == ST_BUSY);

  // Select the current owner's request fields
  always_comb begin
    own_valid_s = 1'b0;
    own_addr_s  = 32'h0000_0000;
    own_wdata_s = 32'h0000_0000;
    own_wstrb_s = 4'b0000;
    if (owner_r) begin
      own_valid_s = m1_valid;
      own_addr_s  = m1_addr;
      own_wdata_s = m1_wdata;
      own_wstrb_s = m1_wstrb;
    end else begin
      own_valid_s = m0_valid;
      own_addr_s  = m0_addr;
      own_wdata_s = m0_wdata;
      own_wstrb_s = m0_wstrb;
    end
  end

  // s_ready only counts while a request is actually presented to the slave
  assign done_s = busy_s & own_valid_s & s_ready;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] stall_cnt_r;

  // Stall counter: held at zero while idle so it starts clear in BUSY
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (!busy_s) begin
      stall_cnt_r <= 16'd0;
    end else if (!s_ready) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // A slave ready in the limit cycle wins over the watchdog
  assign timeout_hit_s = busy_s & own_valid_s & ~s_ready & (stall_cnt_r == TO_LAST);
`else
  logic timeout_cfg_unused_s;
  assign timeout_cfg_unused_s = ^TIMEOUT_CYCLES;
  assign timeout_hit_s        = 1'b0;
`endif

  assign complete_s  = done_s | timeout_hit_s;
  assign cpl_rdata_s = done_s ? s_rdata : ERR_RDATA;
  assign timeout_err = timeout_hit_s;

  // Arbitration and transaction sequencing
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_owner_nxt_s = last_owner_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_valid && m1_valid) begin
          owner_nxt_s = ~last_owner_r;
          state_nxt_s = ST_BUSY;
        end else if (m0_valid) begin
          owner_nxt_s = 1'b0;
          state_nxt_s = ST_BUSY;
        end else if (m1_valid) begin
          owner_nxt_s = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An owner that drops valid early is released without a ready
        if (complete_s || !own_valid_s) begin
          state_nxt_s      = ST_IDLE;
          last_owner_nxt_s = owner_r;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner and grant registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      grant        <= 2'b00;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      if (state_nxt_s == ST_BUSY) begin
        grant <= owner_nxt_s ? 2'b10 : 2'b01;
      end else begin
        grant <= 2'b00;
      end
    end
  end

  // Slave-side mux and master completion steering
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = 32'h0000_0000;
    s_wdata  = 32'h0000_0000;
    s_wstrb  = 4'b0000;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = 32'h0000_0000;
    m1_rdata = 32'h0000_0000;
    if (busy_s) begin
      s_valid = own_valid_s & ~timeout_hit_s;
      s_addr  = own_addr_s;
      s_wdata = own_wdata_s;
      s_wstrb = own_wstrb_s;
    end else begin
      s_valid = 1'b0;
    end
    if (complete_s) begin
      if (owner_r) begin
        m1_ready = 1'b1;
        m1_rdata = cpl_rdata_s;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = cpl_rdata_s;
      end
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_subsys_bus_arbiter.sv
// Self-checking bench for mcu_subsys_bus_arbiter: directed scenarios plus a
// randomized request phase checked against a transaction-level model
// (pending flags per master and the last served master).
module tb_mcu_subsys_bus_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state
  logic [31:0] pl_addr  [2];
  logic [31:0] pl_wdata [2];
  logic [3:0]  pl_wstrb [2];
  bit          pend [2];
  bit          mdl_last;
  int          own;
  int          rdy_cnt [2];
  logic [31:0] rd;

  always #5 sys_clk = ~sys_clk;

  mcu_subsys_bus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_m(input int idx, input bit v);
    if (idx == 0) begin
      m0_valid = v; m0_addr = pl_addr[0]; m0_wdata = pl_wdata[0]; m0_wstrb = pl_wstrb[0];
    end else begin
      m1_valid = v; m1_addr = pl_addr[1]; m1_wdata = pl_wdata[1]; m1_wstrb = pl_wstrb[1];
    end
  endtask

  task automatic new_payload(input int idx);
    pl_addr[idx]  = $urandom;
    pl_wdata[idx] = $urandom;
    pl_wstrb[idx] = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_ready = 1'b0;
    s_rdata = 32'h0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mdl_last = 1'b1;
  endtask

  // Called in an idle cycle with the request(s) already driven. Expects the
  // grant one edge later, stalls the slave `waits` cycles, then completes.
  task automatic serve(input int waits, input logic [31:0] rdv, input logic [1:0] eg,
                       input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es);
    int n;
    n = 0;
    s_ready = 1'b0;
    s_rdata = 32'h0;
    #1;
    chk("idle_grant", grant, 64'd0);
    chk("idle_svalid", s_valid, 64'd0);
    while (s_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("arb_latency", n, 64'd1);
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) tick();
      s_ready = (i == waits);
      s_rdata = (i == waits) ? rdv : 32'h5555_AAAA;
      #1;
      chk("grant", grant, 64'(eg));
      chk("s_valid", s_valid, 64'd1);
      chk("s_addr", s_addr, 64'(ea));
      chk("s_wdata", s_wdata, 64'(ew));
      chk("s_wstrb", s_wstrb, 64'(es));
      chk("timeout_err", timeout_err, 64'd0);
      if (i < waits) begin
        chk("hold_ready", {m1_ready, m0_ready}, 64'd0);
        chk("hold_rdata", {m1_rdata, m0_rdata}, 64'd0);
      end else begin
        chk("ready", {m1_ready, m0_ready}, 64'(eg));
        chk("rdata", {m1_rdata, m0_rdata}, eg[1] ? {rdv, 32'h0} : {32'h0, rdv});
      end
    end
  endtask

  // Ends the completion cycle and checks the following idle cycle
  task automatic close_txn(input bit drop0, input bit drop1);
    if (drop0) m0_valid = 1'b0;
    if (drop1) m1_valid = 1'b0;
    tick();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    #1;
    chk("post_grant", grant, 64'd0);
    chk("post_svalid", s_valid, 64'd0);
    chk("post_ready", {m1_ready, m0_ready}, 64'd0);
    chk("post_timeout", timeout_err, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;

    // Reset state
    do_reset();
    #1;
    chk("rst_grant", grant, 64'd0);
    chk("rst_svalid", s_valid, 64'd0);
    chk("rst_ready", {m1_ready, m0_ready}, 64'd0);
    chk("rst_timeout", timeout_err, 64'd0);
    chk("rst_sbus", {s_addr, s_wdata[27:0], s_wstrb}, 64'd0);
    // s_ready with nothing outstanding is ignored
    s_ready = 1'b1;
    s_rdata = 32'hFFFF_FFFF;
    tick();
    chk("idle_sready_ignored", {m1_ready, m0_ready, m0_rdata}, 64'd0);
    chk("idle_sready_grant", grant, 64'd0);

    // Single m0 read, zero-wait slave
    pl_addr[0] = 32'h0000_0010; pl_wdata[0] = 32'h0; pl_wstrb[0] = 4'b0000;
    drive_m(0, 1'b1);
    serve(0, 32'h1234_5678, 2'b01, 32'h0000_0010, 32'h0, 4'b0000);
    close_txn(1'b1, 1'b0);

    // Simultaneous requests after reset, two wait states
    do_reset();
    pl_addr[0] = 32'h0000_0100; pl_wdata[0] = 32'h0; pl_wstrb[0] = 4'b0000;
    pl_addr[1] = 32'h0000_0200; pl_wdata[1] = 32'h0BAD_CAFE; pl_wstrb[1] = 4'b1111;
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    serve(2, 32'hA0A0_0001, 2'b01, pl_addr[0], pl_wdata[0], pl_wstrb[0]);
    close_txn(1'b1, 1'b0);
    serve(2, 32'hA0A0_0002, 2'b10, pl_addr[1], pl_wdata[1], pl_wstrb[1]);
    close_txn(1'b0, 1'b1);

    // Continuous requests from both: strict alternation, 4 readies each
    do_reset();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    new_payload(0);
    new_payload(1);
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      own = mdl_last ? 0 : 1;
      rd = $urandom;
      serve($urandom_range(0, 2), rd, (own == 1) ? 2'b10 : 2'b01,
            pl_addr[own], pl_wdata[own], pl_wstrb[own]);
      if (m0_ready === 1'b1) rdy_cnt[0]++;
      if (m1_ready === 1'b1) rdy_cnt[1]++;
      mdl_last = (own == 1);
      new_payload(own);
      drive_m(own, 1'b1);
      close_txn(1'b0, 1'b0);
    end
    chk("alt_m0_readies", rdy_cnt[0], 64'd4);
    chk("alt_m1_readies", rdy_cnt[1], 64'd4);
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    // Randomized requests against the transaction model
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
          pend[m] = 1'b1;
          new_payload(m);
          drive_m(m, 1'b1);
        end
      end
      if (!pend[0] && !pend[1]) begin
        tick();
        chk("rnd_idle_grant", grant, 64'd0);
        chk("rnd_idle_svalid", s_valid, 64'd0);
      end else begin
        own = (pend[0] && pend[1]) ? (mdl_last ? 0 : 1) : (pend[1] ? 1 : 0);
        serve($urandom_range(0, 3), $urandom, (own == 1) ? 2'b10 : 2'b01,
              pl_addr[own], pl_wdata[own], pl_wstrb[own]);
        pend[own] = 1'b0;
        mdl_last = (own == 1);
        close_txn(own == 0, own == 1);
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();

    // m1 write, m0 requests mid-transaction and waits for IDLE
    pl_addr[1] = 32'h8000_0004; pl_wdata[1] = 32'hCAFE_F00D; pl_wstrb[1] = 4'b0011;
    drive_m(1, 1'b1);
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_grant", grant, 64'd2);
      chk("mid_s_wstrb", s_wstrb, 64'd3);
      chk("mid_s_wdata", s_wdata, 64'hCAFE_F00D);
      chk("mid_s_addr", s_addr, 64'h8000_0004);
      chk("mid_ready", {m1_ready, m0_ready}, 64'd0);
      if (i == 0) begin
        pl_addr[0] = 32'h0000_0020; pl_wdata[0] = 32'h0; pl_wstrb[0] = 4'b0000;
        drive_m(0, 1'b1);
      end
    end
    s_ready = 1'b1;
    s_rdata = 32'h0000_0000;
    #1;
    chk("mid_m1_done", {m1_ready, m0_ready}, 64'd2);
    close_txn(1'b0, 1'b1);
    serve(0, 32'h7777_0020, 2'b01, 32'h0000_0020, 32'h0, 4'b0000);
    close_txn(1'b1, 1'b0);

    // Reset while BUSY with the slave stalled
    pl_addr[0] = 32'h0000_0030; pl_wdata[0] = 32'h0; pl_wstrb[0] = 4'b0000;
    drive_m(0, 1'b1);
    tick();
    chk("rb_grant", grant, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_grant_after", grant, 64'd0);
    chk("rb_svalid_after", s_valid, 64'd0);
    chk("rb_ready_after", {m1_ready, m0_ready}, 64'd0);
    serve(0, 32'h3030_3030, 2'b01, 32'h0000_0030, 32'h0, 4'b0000);
    close_txn(1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: slave never ready, forced completion in the 4th BUSY cycle
    pl_addr[0] = 32'h0000_0040;
    drive_m(0, 1'b1);
    s_ready = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (c < 4) begin
        chk("to_wait_err", timeout_err, 64'd0);
        chk("to_wait_ready", {m1_ready, m0_ready}, 64'd0);
        chk("to_wait_svalid", s_valid, 64'd1);
      end else begin
        chk("to_hit_err", timeout_err, 64'd1);
        chk("to_hit_ready", {m1_ready, m0_ready}, 64'd1);
        chk("to_hit_rdata", m0_rdata, 64'hDEAD_BEEF);
        chk("to_hit_svalid", s_valid, 64'd0);
      end
    end
    close_txn(1'b1, 1'b0);
    // s_ready in the limit cycle: normal completion
    drive_m(0, 1'b1);
    serve(3, 32'h4444_0040, 2'b01, 32'h0000_0040, 32'h0, 4'b0000);
    close_txn(1'b1, 1'b0);
`else
    // Without the watchdog a long stall just waits
    pl_addr[0] = 32'h0000_0040;
    drive_m(0, 1'b1);
    serve(7, 32'h4444_0040, 2'b01, 32'h0000_0040, 32'h0, 4'b0000);
    close_txn(1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_subsys_bus_arbiter.md
Name: mcu_subsys_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the MCU subsystem native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Sits upstream of the host bridge address decoder and shares it between master 0 (CPU) and master 1 (DMA / debug loader).
- Round-robin grant with a registered owner. The owner holds the bus for exactly one transaction.
- Optional watchdog completes transactions the slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in BUSY without s_ready before a forced completion. Used only with ARB_TIMEOUT_EN. Legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 completion strobe, one cycle
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 means read
- m0_rdata  out  32  master 0 read data, valid when m0_ready
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as master 0, for master 1
- s_valid  out  1  request to slave (host bridge)
- s_ready  in  1  slave completion
- s_addr  out  32  muxed address
- s_wdata  out  32  muxed write data
- s_wstrb  out  4  muxed strobes
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle
- timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE. grant=00, last_owner=1 so m0 wins the first tie.
  - s_valid, m0_ready, m1_ready and timeout_err read 0.
  - s_addr, s_wdata, s_wstrb read 0 while idle.
  - Reset mid-transaction abandons it. No ready is issued to either master.
- State IDLE:
  - Only m0 valid: owner=0. Only m1 valid: owner=1.
  - Both valid: owner = the master that is not last_owner.
  - Neither valid: stay in IDLE.
  - On a request, register the owner and move to BUSY. grant updates on the same edge.
- State BUSY:
  - s_valid, s_addr, s_wdata and s_wstrb are combinationally muxed from the owner's inputs.
  - Slave-facing outputs are 0 when idle.
- Completion:
  - When s_valid & s_ready, the owner's mX_ready=1 and mX_rdata=s_rdata in that cycle.
  - Next edge: state goes to IDLE, last_owner=owner, grant=00.
- Latency:
  - One arbitration cycle. A request seen in IDLE at edge N drives s_valid from cycle N+1.
  - Minimum transaction is 2 cycles with a zero-wait slave.
  - Back-to-back requests leave one idle cycle between transactions.
- Non-owner signals:
  - Non-owner mX_ready is always 0.
  - Non-owner mX_rdata = 0. Owner mX_rdata = 0 except in its ready cycle.
- Owner abort: if the owner drops valid in BUSY before s_ready, s_valid falls with it. Next edge goes to IDLE with no ready and last_owner=owner. This is a protocol violation; it is handled but never relied on.
- Simultaneous events:
  - A new request from the other master during BUSY is held off until IDLE.
  - With continuous requests from both masters, grants strictly alternate: m0, m1, m0, ...
- s_ready asserted while s_valid=0 is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ready=0, that cycle completes the transaction:
    - s_valid=0
    - owner mX_ready=1
    - mX_rdata=ERR_RDATA
    - timeout_err=1
  - Next edge goes to IDLE.
  - s_ready arriving in the same cycle as the limit wins: normal completion, no error.
- Undefined:
  - No counter. BUSY waits indefinitely.
  - timeout_err is tied to 0 and ERR_RDATA is unused.

Test Plan:
- Reset then m0 read of 0x0000_0010 with zero-wait slave, s_rdata=0x1234_5678:
  - grant=01 one cycle after valid, s_valid for one cycle.
  - m0_ready with m0_rdata=0x1234_5678.
  - m1_ready stays 0.
- m0 and m1 both valid in the same cycle after reset, slave 2 wait states:
  - m0 served first, then m1 after one IDLE cycle.
  - grant sequence 01, 00, 10.
  - s_addr matches the owner's address throughout.
- m0 and m1 continuously requesting for 8 transactions: grants alternate m0, m1 x4 and each master gets exactly 4 readies.
- m1 write 0xCAFE_F00D, wstrb=4'b0011 to 0x8000_0004 while m0 requests mid-transaction:
  - s_wstrb=0011 and s_wdata=0xCAFE_F00D until s_ready.
  - m0 granted only after IDLE.
- rst asserted in BUSY with slave stalled: next cycle grant=00, s_valid=0, no mX_ready. A fresh m0 request then completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never ready, m0 read:
  - m0_ready and timeout_err pulse in the 4th BUSY cycle with m0_rdata=0xDEAD_BEEF.
  - Repeat with s_ready in the 4th cycle: normal data, timeout_err=0.
